// File: rtl/mips_fetch_unit_if.sv
// mips_fetch_unit_if: memory req/ack and core valid/ready bundle.
// master = fetch unit side, slave = memory/core side.
interface mips_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output instr_valid, instr, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  instr_valid, instr, instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: single-outstanding fetch FSM + prefetch FIFO.
// Define FETCH_NOP_FILTER_EN to drop all-zero (sll $0,$0,0) words.
module mips_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  mips_fetch_unit_if.master bus,
  output logic             busy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PEND = 2'd1;
  localparam logic [1:0] S_DISC = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   pc_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_nx;
  logic [31:0]   redir_pc, pc_inc;
  logic          ack_kept, push, pop;
  logic          unused_lsb;

  assign unused_lsb = ^redirect_pc[1:0];
  assign redir_pc   = {redirect_pc[31:2], 2'b00};
  assign pc_inc     = fetch_pc_q + 32'd4;
  assign pop        = bus.instr_valid && bus.instr_ready;
  assign ack_kept   = (state_q == S_PEND) && bus.imem_ack && !redirect;

`ifdef FETCH_NOP_FILTER_EN
  assign push = ack_kept && (bus.imem_rdata != 32'h0000_0000);
`else
  assign push = ack_kept;
`endif

  assign count_nx = count_q + (push ? CNT_ONE : '0)
                            - (pop  ? CNT_ONE : '0);

  assign bus.imem_req    = (state_q != S_IDLE);
  assign bus.imem_addr   = addr_q;
  assign bus.instr_valid = (count_q != '0);
  assign bus.instr       = data_q[rd_ptr_q];
  assign bus.instr_pc    = pc_q[rd_ptr_q];
  assign busy            = bus.imem_req || bus.instr_valid;

  // Request FSM: issue, keep or drop responses, follow redirects.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    case (state_q)
      S_IDLE: begin
        if (redirect) begin
          fetch_pc_d = redir_pc;
        end else if (run && count_q < DEPTH_C) begin
          state_d = S_PEND;
          addr_d  = fetch_pc_q;
        end
      end
      S_PEND: begin
        if (redirect) begin
          fetch_pc_d = redir_pc;
          state_d    = bus.imem_ack ? S_IDLE : S_DISC;
        end else if (bus.imem_ack) begin
          fetch_pc_d = pc_inc;
          if (run && count_nx < DEPTH_C) begin
            state_d = S_PEND;
            addr_d  = pc_inc;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DISC: begin
        if (redirect) fetch_pc_d = redir_pc;
        if (bus.imem_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM, fetch PC and request address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  // Prefetch FIFO: push kept words, pop on handshake, flush on redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (redirect) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q] <= bus.imem_rdata;
        pc_q[wr_ptr_q]   <= addr_q;
        wr_ptr_q         <= wr_ptr_q + PTR_ONE;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_nx;
    end
  end
endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb_mips_fetch_unit: directed checks of the fetch unit.
// Second instance exercises RESET_PC wrap-around.
module tb_mips_fetch_unit;
  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        busy, busy2;
  logic        ready = 1'b1;
  logic        auto = 1'b1;
  logic        zero_en = 1'b0;
  logic        man_ack = 1'b0;
  logic [31:0] man_rdata = 32'h0;
  logic        a_auto, a2;
  logic [31:0] d_auto, d2;
  logic        run2 = 1'b0;
  int          checks = 0;
  int          errors = 0;

  mips_fetch_unit_if bus ();
  mips_fetch_unit_if bus2 ();

  mips_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .bus(bus), .busy(busy)
  );

  mips_fetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst_n(rst_n), .run(run2),
    .redirect(1'b0), .redirect_pc(32'h0),
    .bus(bus2), .busy(busy2)
  );

  always #5 clk = ~clk;

  assign bus.imem_ack    = auto ? a_auto : man_ack;
  assign bus.imem_rdata  = auto ? d_auto : man_rdata;
  assign bus.instr_ready = ready;
  assign bus2.imem_ack    = a2;
  assign bus2.imem_rdata  = d2;
  assign bus2.instr_ready = 1'b1;

  // Zero-wait memory: ack in the cycle after the request.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_auto <= 1'b0;
      d_auto <= 32'h0;
    end else if (bus.imem_req && !a_auto) begin
      a_auto <= 1'b1;
      d_auto <= (zero_en && bus.imem_addr == 32'h4) ? 32'h0
                                                    : bus.imem_addr ^ K;
    end else begin
      a_auto <= 1'b0;
    end
  end

  // Same memory for the second instance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a2 <= 1'b0;
      d2 <= 32'h0;
    end else if (bus2.imem_req && !a2) begin
      a2 <= 1'b1;
      d2 <= bus2.imem_addr ^ K;
    end else begin
      a2 <= 1'b0;
    end
  end

  task automatic do_reset();
    rst_n    = 1'b0;
    redirect = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run   = 1'b0;
    ready = 1'b1;
    auto  = 1'b1;
    repeat (2) @(negedge clk);
    checks += 6;
    if (bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL rst_req got %b exp 0", bus.imem_req);
    end
    if (bus.imem_addr !== 32'h0) begin
      errors++; $display("FAIL rst_addr got %h exp 0", bus.imem_addr);
    end
    if (bus.instr_valid !== 1'b0) begin
      errors++; $display("FAIL rst_valid got %b exp 0", bus.instr_valid);
    end
    if (bus.instr !== 32'h0) begin
      errors++; $display("FAIL rst_instr got %h exp 0", bus.instr);
    end
    if (bus.instr_pc !== 32'h0) begin
      errors++; $display("FAIL rst_pc got %h exp 0", bus.instr_pc);
    end
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rst_busy got %b exp 0", busy);
    end
  endtask

  task automatic test_sequence();
    int n;
    int last;
    auto = 1'b1; zero_en = 1'b0; ready = 1'b1; run = 1'b1;
    do_reset();
    @(negedge clk);
    checks += 2;
    if (bus.imem_req !== 1'b1) begin
      errors++; $display("FAIL seq_first_req got %b exp 1", bus.imem_req);
    end
    if (bus.imem_addr !== 32'h0) begin
      errors++; $display("FAIL seq_first_addr got %h exp 0", bus.imem_addr);
    end
    n = 0;
    last = 0;
    for (int c = 0; c < 60 && n < 6; c++) begin
      @(negedge clk);
      if (bus.instr_valid && ready) begin
        checks += 2;
        if (bus.instr_pc !== 32'(4 * n)) begin
          errors++;
          $display("FAIL seq_pc got %h exp %h", bus.instr_pc, 32'(4 * n));
        end
        if (bus.instr !== (32'(4 * n) ^ K)) begin
          errors++;
          $display("FAIL seq_instr got %h exp %h", bus.instr,
                   32'(4 * n) ^ K);
        end
        if (n > 0) begin
          checks++;
          if (c - last != 2) begin
            errors++; $display("FAIL seq_gap got %0d exp 2", c - last);
          end
        end
        last = c;
        n++;
      end
    end
    checks++;
    if (n != 6) begin
      errors++; $display("FAIL seq_count got %0d exp 6", n);
    end
  endtask

  task automatic test_full();
    int acks;
    auto = 1'b1; ready = 1'b0; run = 1'b1;
    do_reset();
    acks = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.imem_req && bus.imem_ack) acks++;
    end
    checks += 4;
    if (acks != 4) begin
      errors++; $display("FAIL full_acks got %0d exp 4", acks);
    end
    if (bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL full_req got %b exp 0", bus.imem_req);
    end
    if (bus.instr_valid !== 1'b1) begin
      errors++; $display("FAIL full_valid got %b exp 1", bus.instr_valid);
    end
    if (bus.instr_pc !== 32'h0) begin
      errors++; $display("FAIL full_head got %h exp 0", bus.instr_pc);
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    acks = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.imem_req && bus.imem_ack) acks++;
    end
    checks += 3;
    if (acks != 1) begin
      errors++; $display("FAIL full_refill got %0d exp 1", acks);
    end
    if (bus.instr_pc !== 32'h4) begin
      errors++; $display("FAIL full_head2 got %h exp 4", bus.instr_pc);
    end
    if (bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL full_req2 got %b exp 0", bus.imem_req);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (bus.instr_valid !== 1'b0) begin
      errors++; $display("FAIL arst_valid got %b exp 0", bus.instr_valid);
    end
    if (busy !== 1'b0) begin
      errors++; $display("FAIL arst_busy got %b exp 0", busy);
    end
    if (bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL arst_req got %b exp 0", bus.imem_req);
    end
    if (bus.imem_addr !== 32'h0) begin
      errors++; $display("FAIL arst_addr got %h exp 0", bus.imem_addr);
    end
  endtask

  task automatic test_redirect_pend();
    auto = 1'b0; man_ack = 1'b0; ready = 1'b1; run = 1'b1;
    do_reset();
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h0000_1003;
    @(negedge clk);
    redirect = 1'b0;
    checks += 2;
    if (bus.imem_req !== 1'b1) begin
      errors++; $display("FAIL rdp_hold_req got %b exp 1", bus.imem_req);
    end
    if (bus.imem_addr !== 32'h0) begin
      errors++; $display("FAIL rdp_hold_addr got %h exp 0", bus.imem_addr);
    end
    repeat (2) @(negedge clk);
    man_ack = 1'b1;
    man_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    man_ack = 1'b0;
    checks += 2;
    if (bus.instr_valid !== 1'b0) begin
      errors++; $display("FAIL rdp_drop got %b exp 0", bus.instr_valid);
    end
    if (bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL rdp_idle got %b exp 0", bus.imem_req);
    end
    for (int c = 0; c < 10 && !bus.imem_req; c++) @(negedge clk);
    checks += 2;
    if (bus.imem_req !== 1'b1) begin
      errors++; $display("FAIL rdp_newreq got %b exp 1", bus.imem_req);
    end
    if (bus.imem_addr !== 32'h0000_1000) begin
      errors++;
      $display("FAIL rdp_newaddr got %h exp 00001000", bus.imem_addr);
    end
    man_ack = 1'b1;
    man_rdata = 32'h1234_5678;
    run = 1'b0;
    @(negedge clk);
    man_ack = 1'b0;
    checks += 3;
    if (bus.instr_valid !== 1'b1) begin
      errors++; $display("FAIL rdp_valid got %b exp 1", bus.instr_valid);
    end
    if (bus.instr_pc !== 32'h0000_1000) begin
      errors++; $display("FAIL rdp_pc got %h exp 00001000", bus.instr_pc);
    end
    if (bus.instr !== 32'h1234_5678) begin
      errors++; $display("FAIL rdp_instr got %h exp 12345678", bus.instr);
    end
  endtask

  task automatic test_redirect_ack_pop();
    auto = 1'b0; man_ack = 1'b0; ready = 1'b0; run = 1'b1;
    do_reset();
    @(negedge clk);
    man_ack = 1'b1;
    man_rdata = 32'hAAAA_0000;
    @(negedge clk);
    checks += 3;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0) begin
      errors++;
      $display("FAIL rap_first got v=%b pc=%h exp v=1 pc=0",
               bus.instr_valid, bus.instr_pc);
    end
    if (bus.imem_req !== 1'b1) begin
      errors++; $display("FAIL rap_b2b_req got %b exp 1", bus.imem_req);
    end
    if (bus.imem_addr !== 32'h4) begin
      errors++; $display("FAIL rap_b2b_addr got %h exp 4", bus.imem_addr);
    end
    man_rdata = 32'hBBBB_0004;
    redirect = 1'b1;
    redirect_pc = 32'h0000_2000;
    ready = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    redirect = 1'b0;
    ready = 1'b0;
    checks += 3;
    if (bus.instr_valid !== 1'b0) begin
      errors++; $display("FAIL rap_flush got %b exp 0", bus.instr_valid);
    end
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rap_busy got %b exp 0", busy);
    end
    if (bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL rap_idle got %b exp 0", bus.imem_req);
    end
    @(negedge clk);
    checks += 2;
    if (bus.imem_req !== 1'b1) begin
      errors++; $display("FAIL rap_newreq got %b exp 1", bus.imem_req);
    end
    if (bus.imem_addr !== 32'h0000_2000) begin
      errors++;
      $display("FAIL rap_newaddr got %h exp 00002000", bus.imem_addr);
    end
    run = 1'b0;
    man_ack = 1'b1;
    man_rdata = 32'hCCCC_2000;
    @(negedge clk);
    man_ack = 1'b0;
    checks += 4;
    if (bus.instr_valid !== 1'b1) begin
      errors++; $display("FAIL rap_valid got %b exp 1", bus.instr_valid);
    end
    if (bus.instr_pc !== 32'h0000_2000) begin
      errors++; $display("FAIL rap_pc got %h exp 00002000", bus.instr_pc);
    end
    if (bus.instr !== 32'hCCCC_2000) begin
      errors++; $display("FAIL rap_instr got %h exp CCCC2000", bus.instr);
    end
    if (bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL rap_stop got %b exp 0", bus.imem_req);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    int n;
    exp_pc[0] = 32'hFFFF_FFF8;
    exp_pc[1] = 32'hFFFF_FFFC;
    exp_pc[2] = 32'h0000_0000;
    run2 = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      @(negedge clk);
      if (bus2.instr_valid) begin
        checks += 2;
        if (bus2.instr_pc !== exp_pc[n]) begin
          errors++;
          $display("FAIL wrap_pc got %h exp %h", bus2.instr_pc, exp_pc[n]);
        end
        if (bus2.instr !== (exp_pc[n] ^ K)) begin
          errors++;
          $display("FAIL wrap_instr got %h exp %h", bus2.instr,
                   exp_pc[n] ^ K);
        end
        n++;
      end
    end
    run2 = 1'b0;
    checks++;
    if (n != 3) begin
      errors++; $display("FAIL wrap_count got %0d exp 3", n);
    end
  endtask

  task automatic test_nop();
    logic [31:0] exp_pc [3];
    logic [31:0] exp_in;
    int n;
`ifdef FETCH_NOP_FILTER_EN
    exp_pc[0] = 32'h0; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC;
`else
    exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8;
`endif
    auto = 1'b1; zero_en = 1'b1; ready = 1'b1; run = 1'b1;
    do_reset();
    n = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      @(negedge clk);
      if (bus.instr_valid) begin
        exp_in = (exp_pc[n] == 32'h4) ? 32'h0 : exp_pc[n] ^ K;
        checks += 2;
        if (bus.instr_pc !== exp_pc[n]) begin
          errors++;
          $display("FAIL nop_pc got %h exp %h", bus.instr_pc, exp_pc[n]);
        end
        if (bus.instr !== exp_in) begin
          errors++;
          $display("FAIL nop_instr got %h exp %h", bus.instr, exp_in);
        end
        n++;
      end
    end
    run = 1'b0;
    zero_en = 1'b0;
    checks++;
    if (n != 3) begin
      errors++; $display("FAIL nop_count got %0d exp 3", n);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_full();
    test_async_reset();
    test_redirect_pend();
    test_redirect_ack_pop();
    test_wrap();
    test_nop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
